// File: rtl/pdl_alarm_responder.sv
// PDL clock-glitch alarm responder: warm-up blanking, per-sensor masking,
// threshold-in-window debounce, halt req/ack handshake and latched fault.
// Optional build macro PDL_ALARM_RST_REQ_EN adds rst_req_o for the system
// reset controller.
module pdl_alarm_responder #(
    parameter int unsigned N_SENSORS     = 2,
    parameter int unsigned WARMUP_CYCLES = 4,
    parameter int unsigned WINDOW        = 16,
    parameter int unsigned THRESHOLD     = 2,
    parameter int unsigned ACK_TIMEOUT   = 64,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] alarm_i,
    input  logic [N_SENSORS-1:0] mask_i,
    input  logic                 clear_i,
    input  logic                 halt_ack_i,
    output logic                 halt_req_o,
    output logic                 fault_o,
    output logic [1:0]           state_o,
    output logic [N_SENSORS-1:0] sensor_id_o,
    output logic [CNT_W-1:0]     event_cnt_o
`ifdef PDL_ALARM_RST_REQ_EN
    ,
    output logic                 rst_req_o
`endif
);

    localparam int unsigned WarmW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int unsigned WinW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned HitW  = $clog2(THRESHOLD + 1);
    localparam int unsigned ToW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);
    localparam logic [WinW-1:0]  WinLast  = WinW'(WINDOW - 1);
    localparam logic [HitW-1:0]  HitLast  = HitW'(THRESHOLD - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StWarmup  = 2'd0,
        StMonitor = 2'd1,
        StHalt    = 2'd2,
        StLocked  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [N_SENSORS-1:0] alarm_q, alarm_d;
    logic [WarmW-1:0]     warm_cnt_q, warm_cnt_d;
    logic [WinW-1:0]      win_cnt_q, win_cnt_d;
    logic [HitW-1:0]      hit_cnt_q, hit_cnt_d;
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;
    logic                 halt_req_q, halt_req_d;
    logic                 fault_q, fault_d;
    logic [N_SENSORS-1:0] sensor_id_q, sensor_id_d;
    logic [CNT_W-1:0]     event_cnt_q, event_cnt_d;
    logic                 rst_req_q, rst_req_d;
    logic                 rst_hold_q, rst_hold_d;
    logic                 hit;

    assign hit = |alarm_q;

    // Next-state and output logic; every register defaults to holding its value.
    always_comb begin
        state_d     = state_q;
        alarm_d     = alarm_i & ~mask_i;
        warm_cnt_d  = warm_cnt_q;
        win_cnt_d   = win_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        to_cnt_d    = to_cnt_q;
        halt_req_d  = halt_req_q;
        fault_d     = fault_q;
        sensor_id_d = sensor_id_q;
        event_cnt_d = event_cnt_q;
        rst_req_d   = rst_req_q;
        rst_hold_d  = rst_hold_q;

        // Hits are captured everywhere except during sensor settling.
        if (state_q != StWarmup) begin
            sensor_id_d = sensor_id_q | alarm_q;
            if (hit && (event_cnt_q != {CNT_W{1'b1}})) begin
                event_cnt_d = event_cnt_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            StWarmup: begin
                if (warm_cnt_q == WarmLast) begin
                    state_d    = StMonitor;
                    warm_cnt_d = '0;
                    win_cnt_d  = '0;
                    hit_cnt_d  = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + WarmW'(1);
                end
            end
            StMonitor: begin
                if (win_cnt_q == WinLast) begin
                    win_cnt_d = '0;
                    hit_cnt_d = hit ? HitW'(1) : '0;
                end else begin
                    win_cnt_d = win_cnt_q + WinW'(1);
                    if (hit) hit_cnt_d = hit_cnt_q + HitW'(1);
                end
                // Threshold check takes priority over the window wrap.
                if (hit && (hit_cnt_q == HitLast)) begin
                    state_d    = StHalt;
                    halt_req_d = 1'b1;
                    to_cnt_d   = '0;
                end
            end
            StHalt: begin
                to_cnt_d = to_cnt_q + ToW'(1);
                if (halt_ack_i || (to_cnt_q == ToLast)) begin
                    state_d    = StLocked;
                    halt_req_d = 1'b0;
                    fault_d    = 1'b1;
                    rst_req_d  = 1'b1;
                    // Without an ack the core never confirmed; keep requesting reset.
                    rst_hold_d = ~halt_ack_i;
                end
            end
            StLocked: begin
                if (clear_i) begin
                    state_d     = StWarmup;
                    fault_d     = 1'b0;
                    sensor_id_d = '0;
                    hit_cnt_d   = '0;
                    win_cnt_d   = '0;
                    warm_cnt_d  = '0;
                    to_cnt_d    = '0;
                    rst_req_d   = 1'b0;
                    rst_hold_d  = 1'b0;
                end else begin
                    rst_req_d = rst_hold_q;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWarmup;
            alarm_q     <= '0;
            warm_cnt_q  <= '0;
            win_cnt_q   <= '0;
            hit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            halt_req_q  <= 1'b0;
            fault_q     <= 1'b0;
            sensor_id_q <= '0;
            event_cnt_q <= '0;
            rst_req_q   <= 1'b0;
            rst_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            warm_cnt_q  <= warm_cnt_d;
            win_cnt_q   <= win_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            halt_req_q  <= halt_req_d;
            fault_q     <= fault_d;
            sensor_id_q <= sensor_id_d;
            event_cnt_q <= event_cnt_d;
            rst_req_q   <= rst_req_d;
            rst_hold_q  <= rst_hold_d;
        end
    end

    assign halt_req_o  = halt_req_q;
    assign fault_o     = fault_q;
    assign state_o     = state_q;
    assign sensor_id_o = sensor_id_q;
    assign event_cnt_o = event_cnt_q;

`ifdef PDL_ALARM_RST_REQ_EN
    assign rst_req_o = rst_req_q;
`else
    logic unused_rst_req;
    assign unused_rst_req = rst_req_q ^ rst_hold_q;
`endif

endmodule

// File: tb/tb_pdl_alarm_responder.sv
// Directed self-checking bench for pdl_alarm_responder (default parameters).
module tb_pdl_alarm_responder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alarm_i;
    logic [1:0]  mask_i;
    logic        clear_i;
    logic        halt_ack_i;
    logic        halt_req_o;
    logic        fault_o;
    logic [1:0]  state_o;
    logic [1:0]  sensor_id_o;
    logic [15:0] event_cnt_o;
`ifdef PDL_ALARM_RST_REQ_EN
    logic        rst_req_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pdl_alarm_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alarm_i     (alarm_i),
        .mask_i      (mask_i),
        .clear_i     (clear_i),
        .halt_ack_i  (halt_ack_i),
        .halt_req_o  (halt_req_o),
        .fault_o     (fault_o),
        .state_o     (state_o),
        .sensor_id_o (sensor_id_o),
        .event_cnt_o (event_cnt_o)
`ifdef PDL_ALARM_RST_REQ_EN
        ,
        .rst_req_o   (rst_req_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release just after an edge, and run the 4 warm-up edges.
    task automatic do_reset();
        rst_n      = 1'b0;
        alarm_i    = '0;
        mask_i     = '0;
        clear_i    = 1'b0;
        halt_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int n;

        // ---- Warm-up blanking ----
        rst_n      = 1'b0;
        alarm_i    = 2'b11;
        mask_i     = '0;
        clear_i    = 1'b0;
        halt_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state_o, 0);
        check("rst_halt", halt_req_o, 0);
        check("rst_fault", fault_o, 0);
        check("rst_sid", sensor_id_o, 0);
        check("rst_evt", event_cnt_o, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("warm_state_e3", state_o, 0);
        alarm_i = '0;
        tick();
        check("warm_state_e4", state_o, 1);
        repeat (3) tick();
        check("warm_evt", event_cnt_o, 0);
        check("warm_halt", halt_req_o, 0);
        check("warm_sid", sensor_id_o, 0);

        // ---- Hits in separate windows ----
        do_reset();
        alarm_i = 2'b01;
        tick();
        alarm_i = 2'b00;
        repeat (19) tick();
        alarm_i = 2'b01;
        tick();
        alarm_i = 2'b00;
        repeat (5) tick();
        check("sep_state", state_o, 1);
        check("sep_halt", halt_req_o, 0);
        check("sep_evt", event_cnt_o, 2);
        check("sep_sid", sensor_id_o, 2'b01);

        // ---- Threshold met, acked ----
        do_reset();
        alarm_i = 2'b10;
        tick();
        alarm_i = 2'b00;
        repeat (2) tick();
        alarm_i = 2'b10;
        tick();
        alarm_i = 2'b00;
        check("thr_halt_early", halt_req_o, 0);
        tick();
        check("thr_halt_rise", halt_req_o, 1);
        check("thr_state_halt", state_o, 2);
        check("thr_sid", sensor_id_o, 2'b10);
        check("thr_evt", event_cnt_o, 2);
        repeat (4) tick();
        check("thr_halt_hold", halt_req_o, 1);
        halt_ack_i = 1'b1;
        tick();
        halt_ack_i = 1'b0;
        check("thr_state_lock", state_o, 3);
        check("thr_fault", fault_o, 1);
        check("thr_halt_fall", halt_req_o, 0);
`ifdef PDL_ALARM_RST_REQ_EN
        check("ack_rstreq_pulse", rst_req_o, 1);
`endif
        tick();
        check("thr_state_stay", state_o, 3);
`ifdef PDL_ALARM_RST_REQ_EN
        check("ack_rstreq_drop", rst_req_o, 0);
`endif
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("thr_clr_state", state_o, 0);
        check("thr_clr_fault", fault_o, 0);
        check("thr_clr_sid", sensor_id_o, 0);
        check("thr_clr_evt", event_cnt_o, 2);

        // ---- Ack timeout ----
        do_reset();
        alarm_i = 2'b01;
        repeat (2) tick();
        alarm_i = 2'b00;
        tick();
        check("to_halt_rise", halt_req_o, 1);
        n = 0;
        while (halt_req_o && n < 200) begin
            tick();
            n++;
        end
        check("to_halt_len", n, 64);
        check("to_state", state_o, 3);
        check("to_fault", fault_o, 1);
        check("to_evt", event_cnt_o, 2);
`ifdef PDL_ALARM_RST_REQ_EN
        check("to_rstreq", rst_req_o, 1);
`endif
        halt_ack_i = 1'b1;
        repeat (3) tick();
        halt_ack_i = 1'b0;
        check("to_ack_ignored", state_o, 3);
`ifdef PDL_ALARM_RST_REQ_EN
        check("to_rstreq_hold", rst_req_o, 1);
`endif
        // Clear coinciding with a hit: clear wins, hit still counted.
        alarm_i = 2'b10;
        tick();
        alarm_i = 2'b00;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clrhit_state", state_o, 0);
        check("clrhit_sid", sensor_id_o, 0);
        check("clrhit_evt", event_cnt_o, 3);
        check("clrhit_fault", fault_o, 0);
`ifdef PDL_ALARM_RST_REQ_EN
        check("clrhit_rstreq", rst_req_o, 0);
`endif

        // ---- Mask and clear ----
        do_reset();
        mask_i = 2'b01;
        for (int i = 0; i < 40; i++) begin
            alarm_i = {1'b0, ~alarm_i[0]};
            tick();
        end
        alarm_i = 2'b00;
        repeat (2) tick();
        check("mask_evt", event_cnt_o, 0);
        check("mask_state", state_o, 1);
        check("mask_sid", sensor_id_o, 0);
        alarm_i = 2'b10;
        repeat (2) tick();
        alarm_i = 2'b00;
        halt_ack_i = 1'b1;
        n = 0;
        while (state_o != 2'd3 && n < 20) begin
            tick();
            n++;
        end
        halt_ack_i = 1'b0;
        check("mask_lock_state", state_o, 3);
        check("mask_lock_sid", sensor_id_o, 2'b10);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("mask_clr_state", state_o, 0);
        check("mask_clr_fault", fault_o, 0);
        check("mask_clr_sid", sensor_id_o, 0);
        check("mask_clr_evt", event_cnt_o, 2);

        // ---- Reset mid-HALT drops the request asynchronously ----
        do_reset();
        alarm_i = 2'b11;
        repeat (2) tick();
        alarm_i = 2'b00;
        tick();
        check("mid_halt_up", halt_req_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_halt_drop", halt_req_o, 0);
        check("mid_state", state_o, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
